counter_top: RTL and testbench



---
 rtl/counter_pkg.sv | 6 +
 rtl/counter_core.sv | 32 +++
 rtl/counter_top.sv | 49 ++++
 tb/tb_counter_top.sv | 113 +++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared state type and default sizing for the Basys3 up-counter.
package counter_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
   localparam int COUNT_WIDTH = 10;
   localparam int COUNT_MAX   = 1023;
endpackage

// File: rtl/counter_core.sv
// counter_core: WIDTH-bit counter register with enable, sync clear and modular STEP wrap.
module counter_core
   import counter_pkg::*;
#(
   parameter int WIDTH     = COUNT_WIDTH,
   parameter int MAX_COUNT = COUNT_MAX,
   parameter int STEP      = 1
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);
   if (MAX_COUNT > (2**WIDTH) - 1 || STEP < 1 || STEP > MAX_COUNT + 1) begin : g_bad_params
      $error("counter_core: illegal WIDTH/MAX_COUNT/STEP combination");
   end
   logic [WIDTH-1:0] r_count;
   logic [WIDTH:0]   w_sum;
   logic             w_ovf;
   logic [WIDTH-1:0] w_next;
   // one spare bit catches the sum running past MAX_COUNT before truncation
   assign w_sum  = {1'b0, r_count} + (WIDTH+1)'(STEP);
   assign w_ovf  = w_sum > (WIDTH+1)'(MAX_COUNT);
   assign w_next = w_ovf ? WIDTH'(w_sum - (WIDTH+1)'(MAX_COUNT + 1)) : WIDTH'(w_sum);
   always_ff @(posedge clk) begin
      if (i_clr)
         r_count <= '0;
      else if (i_en)
         r_count <= w_next;
   end
   assign o_count = r_count;
endmodule

// File: rtl/counter_top.sv
// counter_top: run/hold control FSM around counter_core; count_out drives the board LEDs.
module counter_top
   import counter_pkg::*;
#(
   parameter int WIDTH     = COUNT_WIDTH,
   parameter int MAX_COUNT = COUNT_MAX,
   parameter int STEP      = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:0]       start,
   output logic [WIDTH-1:0] count_out
);
   state_t r_state;
   state_t w_state_nx;
   logic   w_en;
   // an X/Z start compares unknown and falls through to the hold path
   assign w_en = (start == 1'b1);
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nx;
   end
   always_comb begin
      w_state_nx = IDLE;
      case (r_state)
         IDLE:    if (w_en) w_state_nx = RUN; else w_state_nx = IDLE;
         RUN:     if (w_en) w_state_nx = RUN; else w_state_nx = HOLD;
         HOLD:    if (w_en) w_state_nx = RUN; else w_state_nx = HOLD;
         default: w_state_nx = IDLE;
      endcase
   end
   // IDLE means nothing has been counted since reset
   always_ff @(posedge clk) begin
      if (!reset && r_state == IDLE)
         assert (count_out == '0);
   end
   counter_core #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT),
      .STEP      (STEP)
   ) u_core (
      .clk     (clk),
      .i_clr   (reset),
      .i_en    (w_en),
      .o_count (count_out)
   );
endmodule

// File: tb/tb_counter_top.sv
// tb_counter_top: table-driven vectors with a scoreboard queue checking count_out after each edge.
module tb_counter_top;
   typedef struct {
      logic       rst;
      logic [0:0] st;
      logic [9:0] exp;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [0:0] start;
   logic [9:0] count_out;

   vec_t       table_q[$];
   logic [9:0] sb_q[$];
   string      nm_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         cnt   = 0;

   counter_top dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .count_out (count_out)
   );

   always #10 clk = ~clk;

   function automatic void add(input logic r, input logic [0:0] s, input logic [9:0] e, input string n);
      vec_t v;
      v.rst = r; v.st = s; v.exp = e; v.name = n;
      table_q.push_back(v);
   endfunction

   function automatic void do_reset(input int n, input logic [0:0] s, input string nm);
      for (int i = 0; i < n; i++) add(1'b1, s, 10'd0, nm);
      cnt = 0;
   endfunction

   function automatic void run(input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         cnt = (cnt + 1) % 1024;
         add(1'b0, 1'b1, 10'(cnt), nm);
      end
   endfunction

   function automatic void idle(input int n, input logic [0:0] s, input string nm);
      for (int i = 0; i < n; i++) add(1'b0, s, 10'(cnt), nm);
   endfunction

   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         logic [9:0] e;
         string      n;
         e = sb_q.pop_front();
         n = nm_q.pop_front();
         n_vec++;
         if (count_out !== e) begin
            n_err++;
            $display("FAIL %s: count_out=%0d expected %0d", n, count_out, e);
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 1'bx;
      do_reset(2, 1'bx, "reset_hold");
      idle(3, 1'bx, "start_x_hold");
      run(1, "start_after_x");
      do_reset(1, 1'b0, "reset_clear");
      run(10, "basic_count");
      do_reset(1, 1'b0, "reset_pause");
      run(5, "pause_count_to_5");
      idle(4, 1'b0, "pause_hold_5");
      run(3, "resume_to_8");
      do_reset(1, 1'b0, "reset_mid");
      run(37, "count_to_37");
      do_reset(1, 1'b1, "reset_priority");
      run(3, "after_mid_reset");
      do_reset(1, 1'b0, "reset_wrap");
      run(1023, "count_to_max");
      run(2, "wrap_to_zero");
      idle(2, 1'b0, "hold_after_wrap");

      foreach (table_q[i]) begin
         @(negedge clk);
         reset = table_q[i].rst;
         start = table_q[i].st;
         sb_q.push_back(table_q[i].exp);
         nm_q.push_back(table_q[i].name);
      end
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
